tsv_pattern_tx: RTL and testbench
=================================

// Module: tsv_pattern_tx
// PURPOSE
//  Transmit end of the inter-layer TSV self-test link. Generates 32-bit test words
//  (fixed, walking, PRBS), frames each one and shifts it out one bit per clk onto
//  the serial line that feeds the deserializer on the layer under test.
//  Runs in the divided clk domain, one bit per cycle, so the receiver can recover words.
// PARAMETERS
//  DATA_W   32   word width; bits per frame payload
//  CNT_W    8    width of the word_cnt request field
// PORTS
//  clk       in   1       divided link clock; all logic on rising edge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       request a burst; sampled only in IDLE
//  mode      in   3       pattern select, latched at start
//  word_cnt  in   CNT_W   number of words in burst, latched at start
//  seed      in   DATA_W  PRBS seed, latched at start
//  tx_out    out  1       serial line; idles low
//  busy      out  1       high from cycle after accepted start until done
//  done      out  1       1-cycle pulse when burst completes
//  cur_word  out  DATA_W  word currently being framed (debug/scoreboard)
// BEHAVIOUR
//  Reset (async): tx_out=0, busy=0, done=0, cur_word=0, FSM=IDLE; mid-frame reset
//   aborts immediately, no partial frame resumes after release.
//  Frame (DATA_W+3 cycles): START bit 1 | DATA_W bits MSB first | even parity
//   (bit = ^data) | STOP bit 0. Frames back-to-back, no gap between STOP and next START.
//  FSM: IDLE -start&word_cnt!=0-> START -> DATA (DATA_W cycles, bit counter
//   DATA_W-1..0) -> PARITY -> STOP -> (words_left!=0 ? START : FIN) ; FIN -> IDLE.
//  Latency: start seen high at edge N -> busy=1 and tx_out=1 (START) after edge N+1.
//  done pulses in the FIN cycle (cycle after last STOP); busy drops same edge.
//  word_cnt==0: no frame, tx_out stays 0, done pulses after edge N+1, busy stays 0.
//  start while busy: ignored, no queuing. start held high in IDLE after done: new burst.
//  Pattern for word index k (0-based, per burst):
//   0 all-zeros; 1 all-ones; 2 checkerboard: k even 0xAAAAAAAA, k odd 0x55555555;
//   3 walking-one 1<<(k mod DATA_W); 4 walking-zero ~(1<<(k mod DATA_W));
//   5 PRBS: word0=seed (0 forced to 1), then 32-step Galois LFSR advance per word,
//     poly x^32+x^22+x^2+x+1; 6,7 reserved -> behave as mode 0.
//  k wraps modulo DATA_W for walking modes (word 32 == word 0).
//  Next word computed during current frame; loaded into shift reg at START.
//  cur_word updates at START of each frame, holds after burst until next start.
// STRUCTURE
//  Shared defs header tsv_test_defs: mode encodings, FRAME_LEN, START/STOP bit
//   values, PRBS polynomial; reused by self_test-side checker.
//  Sub-module tsv_pattern_gen: mode/seed/k -> next word (registered, advance strobe).
//  Top of this block: framing FSM, shift register, bit and word counters.
// TESTING
//  mode=3,word_cnt=3 -> words 0x1,0x2,0x4; frame0 bits 1,31x0,1,parity 1,stop 0; done after 105 cycles.
//  mode=2,word_cnt=2 -> 0xAAAAAAAA parity 0, 0x55555555 parity 0; frames contiguous.
//  mode=5,seed=0 -> word0=0x00000001; seed=0xDEADBEEF -> word0 0xDEADBEEF, word1 matches model LFSR.
//  word_cnt=0 -> no START bit, done pulse 1 cycle after start, busy never 1.
//  start pulsed again mid-burst -> ignored, total frames = original word_cnt.
//  rst asserted in DATA of frame 1 -> tx_out=0 same cycle, busy=0; new start restarts at k=0.
//  loopback: tx_out -> deserializer -> recovered words equal cur_word sequence.

Source files
------------

// File: rtl/tsv_test_defs_pkg.sv
// ---------------------------------------------------------------------------
// tsv_test_defs_pkg
// Shared definitions for the TSV self-test link. Both the transmit block
// and the receive-side checker import this package, so the pattern
// encodings and frame layout live in one place.
//   - tsv_mode_e : pattern select encodings (6 and 7 are reserved)
//   - tx_state_e : framing FSM states of the transmitter
//   - FRAME_LEN  : serial cycles per framed word
//   - START_BIT / STOP_BIT : framing bit values
//   - PRBS_TAPS  : Galois feedback taps for x^32+x^22+x^2+x+1
// ---------------------------------------------------------------------------
package tsv_test_defs_pkg;

  localparam int TSV_DATA_W = 32;
  localparam int FRAME_LEN  = TSV_DATA_W + 3;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // x^32 term is implicit in the shift-out; the remaining terms are the taps.
  localparam logic [31:0] PRBS_TAPS = 32'h0040_0007;

  typedef enum logic [2:0] {
    MODE_ZERO    = 3'd0,
    MODE_ONES    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_WALK1   = 3'd3,
    MODE_WALK0   = 3'd4,
    MODE_PRBS    = 3'd5,
    MODE_RSV6    = 3'd6,
    MODE_RSV7    = 3'd7
  } tsv_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_FIN    = 3'd6
  } tx_state_e;

endpackage

// File: rtl/tsv_pattern_gen.sv
// ---------------------------------------------------------------------------
// tsv_pattern_gen
// Produces the test word for word index k of a burst. The word is held in
// a register so the framer can grab it at the START of each frame; the
// following word is computed while the current frame is being shifted out.
// Ports:
//   clk       in   link clock
//   rst       in   asynchronous active-high reset
//   load_i    in   begin a burst: latch mode/seed, present word 0
//   mode_i    in   pattern select (tsv_mode_e encoding)
//   seed_i    in   PRBS seed (zero is replaced by 1)
//   advance_i in   current word consumed: present word k+1
//   word_o    out  current word
// ---------------------------------------------------------------------------
module tsv_pattern_gen
  import tsv_test_defs_pkg::*;
#(
  parameter int DATA_W = TSV_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [2:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] word_o
);

  localparam int KW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(PRBS_TAPS);

  // The word index is only KW bits wide, so walking patterns wrap
  // naturally every DATA_W words.
  logic [KW-1:0]     k_q;
  logic [KW-1:0]     k_d;
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_d;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] seed_fix;
  tsv_mode_e         mode_q;

  // One word step of the PRBS = DATA_W single-bit Galois shifts.
  function automatic logic [DATA_W-1:0] prbs_adv(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = s;
    for (int i = 0; i < DATA_W; i++) begin
      r = r[DATA_W-1] ? ((r << 1) ^ TAPS) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input tsv_mode_e m,
                                                input logic [KW-1:0] k,
                                                input logic [DATA_W-1:0] l);
    logic [DATA_W-1:0] one_hot;
    logic [DATA_W-1:0] res;
    one_hot    = '0;
    one_hot[k] = 1'b1;
    case (m)
      MODE_ONES:    res = '1;
      MODE_CHECKER: res = k[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
      MODE_WALK1:   res = one_hot;
      MODE_WALK0:   res = ~one_hot;
      MODE_PRBS:    res = l;
      default:      res = '0;
    endcase
    return res;
  endfunction

  assign seed_fix = (seed_i == '0) ? DATA_W'(1) : seed_i;
  assign k_d      = k_q + 1'b1;
  assign lfsr_d   = prbs_adv(lfsr_q);
  assign word_o   = word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_ZERO;
      k_q    <= '0;
      lfsr_q <= '0;
      word_q <= '0;
    end else if (load_i) begin
      mode_q <= tsv_mode_e'(mode_i);
      k_q    <= '0;
      lfsr_q <= seed_fix;
      word_q <= pattern(tsv_mode_e'(mode_i), '0, seed_fix);
    end else if (advance_i) begin
      k_q    <= k_d;
      lfsr_q <= lfsr_d;
      word_q <= pattern(mode_q, k_d, lfsr_d);
    end
  end

endmodule

// File: rtl/tsv_pattern_tx.sv
// ---------------------------------------------------------------------------
// tsv_pattern_tx
// Transmit end of the TSV self-test link. Frames each generated test word
// as START(1) | DATA_W bits MSB first | even parity | STOP(0) and shifts it
// out one bit per clock. Frames of a burst are back-to-back.
// Ports:
//   clk       in   divided link clock
//   rst       in   asynchronous active-high reset
//   start     in   burst request, sampled only in IDLE
//   mode      in   pattern select, latched at start
//   word_cnt  in   words in burst, latched at start
//   seed      in   PRBS seed, latched at start
//   tx_out    out  serial line, idles low
//   busy      out  high while frames are being sent
//   done      out  one-cycle pulse at burst end
//   cur_word  out  word of the frame currently on the line
// ---------------------------------------------------------------------------
module tsv_pattern_tx
  import tsv_test_defs_pkg::*;
#(
  parameter int DATA_W = TSV_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic [DATA_W-1:0] seed,
  output logic              tx_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] cur_word
);

  localparam int BW = $clog2(DATA_W);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic [BW-1:0]     bit_q;
  logic [CNT_W-1:0]  left_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] cur_q;

  logic [DATA_W-1:0] gen_word;
  logic              gen_load;
  logic              gen_adv;
  logic              more_words;

  // ARM is the one cycle between accepting start and the first START bit;
  // it gives the generator time to present word 0.
  assign more_words = (left_q != '0);
  assign gen_load   = (state_q == ST_IDLE) && start;
  assign gen_adv    = ((state_q == ST_ARM) || (state_q == ST_STOP)) && more_words;

  tsv_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (gen_load),
    .mode_i    (mode),
    .seed_i    (seed),
    .advance_i (gen_adv),
    .word_o    (gen_word)
  );

  // Outputs are registered: each transition drives the line value that
  // belongs to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      left_q   <= '0;
      tx_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cur_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            left_q  <= word_cnt;
            state_q <= ST_ARM;
          end
        end
        // Both the first frame and every back-to-back frame load here.
        ST_ARM, ST_STOP: begin
          if (more_words) begin
            state_q  <= ST_START;
            tx_q     <= START_BIT;
            busy_q   <= 1'b1;
            shift_q  <= gen_word;
            cur_q    <= gen_word;
            parity_q <= ^gen_word;
            left_q   <= left_q - 1'b1;
          end else begin
            state_q <= ST_FIN;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          tx_q    <= shift_q[DATA_W-1];
          shift_q <= shift_q << 1;
          bit_q   <= BW'(DATA_W - 1);
        end
        ST_DATA: begin
          if (bit_q == '0) begin
            state_q <= ST_PARITY;
            tx_q    <= parity_q;
          end else begin
            tx_q    <= shift_q[DATA_W-1];
            shift_q <= shift_q << 1;
            bit_q   <= bit_q - 1'b1;
          end
        end
        ST_PARITY: begin
          state_q <= ST_STOP;
          tx_q    <= STOP_BIT;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_word = cur_q;

endmodule

// File: tb/tb_tsv_pattern_tx.sv
module tb_tsv_pattern_tx;
  import tsv_test_defs_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] word_cnt;
  logic [DW-1:0] seed;
  logic          tx_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] cur_word;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] rx_words[$];
  logic          rx_par[$];

  always #5 clk = ~clk;

  tsv_pattern_tx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .word_cnt (word_cnt),
    .seed     (seed),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done),
    .cur_word (cur_word)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PRBS word step as polynomial arithmetic: next = word * x^32 mod P(x).
  function automatic logic [31:0] mulx32(input logic [31:0] s);
    logic [63:0] v;
    logic [63:0] p;
    v = {s, 32'h0};
    p = 64'h1_0040_0007;
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (p << (i - 32));
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_word(input int m, input int k, input logic [31:0] sd);
    logic [31:0] s;
    logic [31:0] one;
    one = 32'h1;
    case (m)
      1: s = 32'hFFFF_FFFF;
      2: s = (k % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      3: s = one << (k % 32);
      4: s = ~(one << (k % 32));
      5: begin
        s = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < k; i++) s = mulx32(s);
      end
      default: s = 32'h0;
    endcase
    return s;
  endfunction

  // Runs one burst and checks every serial bit, busy/done timing and
  // cur_word against the model; recovered words are kept in rx_words.
  task automatic run_burst(input int m, input int n, input logic [31:0] sd, input bit mid_start);
    logic [31:0] exp_w;
    logic [31:0] rx;
    logic        exp_bit;
    logic        rxp;
    rx_words.delete();
    rx_par.delete();
    rxp = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    mode     = m[2:0];
    word_cnt = n[7:0];
    seed     = sd;
    tick();
    start = 1'b0;
    chk("arm_busy", busy, 0);
    chk("arm_tx", tx_out, 0);
    tick();
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_tx", tx_out, 0);
      tick();
      chk("zero_done_clr", done, 0);
      chk("zero_busy_after", busy, 0);
      $display("burst mode=%0d cnt=%0d seed=0x%08h: empty burst", m, n, sd);
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_w = model_word(m, w, sd);
      rx    = 32'h0;
      for (int b = 0; b < FRAME_LEN; b++) begin
        if (b == 0)       exp_bit = 1'b1;
        else if (b <= 32) exp_bit = exp_w[32-b];
        else if (b == 33) exp_bit = ^exp_w;
        else              exp_bit = 1'b0;
        chk("tx_bit", tx_out, exp_bit);
        chk("busy_done", {busy, done}, 2'b10);
        if (b == 0) chk("cur_word", cur_word, exp_w);
        if (b >= 1 && b <= 32) rx = {rx[30:0], tx_out};
        if (b == 33) rxp = tx_out;
        if (mid_start) start = (w == 0 && b == 10);
        tick();
      end
      rx_words.push_back(rx);
      rx_par.push_back(rxp);
      chk("loopback_word", rx, exp_w);
    end
    start = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_tx", tx_out, 0);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_tx", tx_out, 0);
    $display("burst mode=%0d cnt=%0d seed=0x%08h: %0d frames, first word 0x%08h",
             m, n, sd, rx_words.size(), rx_words[0]);
  endtask

  typedef struct {
    int          m;
    int          n;
    logic [31:0] sd;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        p0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cyc;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 3'd0;
    word_cnt = '0;
    seed     = '0;

    tbl[0] = '{3, 3, 32'h0,         32'h0000_0001, 32'h0000_0002, 1'b1};
    tbl[1] = '{2, 2, 32'h0,         32'hAAAA_AAAA, 32'h5555_5555, 1'b0};
    tbl[2] = '{5, 2, 32'h0,         32'h0000_0001, 32'h0040_0007, 1'b1};
    tbl[3] = '{5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[4] = '{4, 2, 32'h0,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1};
    tbl[5] = '{1, 1, 32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[6] = '{6, 1, 32'h1234_5678, 32'h0,         32'h0,         1'b0};
    tbl[7] = '{7, 2, 32'hFFFF_0000, 32'h0,         32'h0,         1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_word", cur_word, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed vectors
    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].m, tbl[i].n, tbl[i].sd, 1'b0);
      chk("tbl_w0", rx_words[0], tbl[i].w0);
      chk("tbl_p0", rx_par[0], tbl[i].p0);
      if (tbl[i].n > 1) chk("tbl_w1", rx_words[1], tbl[i].w1);
    end

    // PRBS with a real seed: second word from the model LFSR
    run_burst(5, 2, 32'hDEAD_BEEF, 1'b0);
    chk("prbs_w1", rx_words[1], mulx32(32'hDEAD_BEEF));

    // Empty burst
    run_burst(3, 0, 32'h0, 1'b0);

    // Start pulsed during a burst is ignored
    run_burst(2, 3, 32'h0, 1'b1);
    chk("mid_start_frames", rx_words.size(), 3);

    // Walking-one wraps after DATA_W words
    run_burst(3, 34, 32'h0, 1'b0);
    chk("walk_wrap32", rx_words[32], 32'h1);
    chk("walk_wrap33", rx_words[33], 32'h2);

    // Reset during DATA of frame 1 (at the bit where word 0x2 drives a 1)
    @(negedge clk);
    start    = 1'b1;
    mode     = 3'd3;
    word_cnt = 8'd3;
    seed     = 32'h0;
    tick();
    start = 1'b0;
    repeat (1 + 35 + 31) tick();
    chk("pre_rst_tx", tx_out, 1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cur_word", cur_word, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_idle", {busy, tx_out, done}, 3'b000);
    end
    $display("reset mid-frame: line idle after release");
    run_burst(3, 2, 32'h0, 1'b0);

    // Start held high: a new burst begins from IDLE after done
    @(negedge clk);
    mode     = 3'd1;
    word_cnt = 8'd1;
    seed     = 32'h0;
    start    = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    chk("held_first_done", done, 1);
    cyc = 0;
    while (busy !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    chk("held_restart_lat", cyc, 3);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    chk("held_second_done", done, 1);
    tick();
    chk("held_idle", busy, 0);
    $display("held start: restart latency %0d", 3);

    // Randomized bursts against the model
    for (int r = 0; r < 10; r++) begin
      int          rm;
      int          rn;
      logic [31:0] rs;
      rm = int'($urandom_range(0, 7));
      rn = int'($urandom_range(0, 6));
      rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_burst(rm, rn, rs, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
